q_update_engine: RTL and testbench
==================================

Name: q_update_engine

Overview:
- Parametrised Q-learning update engine for the grid-world agent.
- Owns the Q-table internally and accepts one (s, a, r, s') update per valid/ready handshake.
- Scans all next-state actions for max Q, applies shift-based alpha/gamma fixed-point update with saturation, and reports the new value and the greedy next action.
- Also provides a registered host read port and a table-clear sequencer.

Parameters:
- ROWS, 5, grid rows
- COLS, 5, grid columns
- ACTIONS, 4, actions per state (>=2)
- DATA_WIDTH, 8, signed Q/reward width
- ALPHA_SHIFT, 1, learning rate = 2^-ALPHA_SHIFT
- GAMMA_SHIFT, 1, discount = 2^-GAMMA_SHIFT
- TABLE_SIZE, ROWS*COLS*ACTIONS, derived
- ADDR_WIDTH, $clog2(TABLE_SIZE), derived

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  update request
- req_ready  out  1  engine can accept
- row, col, next_row, next_col  in  3 each  state / next-state coordinates
- action  in  $clog2(ACTIONS)  action taken
- reward  in  DATA_WIDTH  signed reward
- terminal  in  1  s' terminal: no bootstrap term
- done_valid  out  1  one-cycle completion pulse
- done_addr  out  ADDR_WIDTH  updated entry address
- done_q  out  DATA_WIDTH  new signed Q value
- done_best_action  out  $clog2(ACTIONS)  argmax action of s'
- done_err  out  1  coordinate out of range; no write made
- clear  in  1  start table clear (sampled in IDLE only)
- busy  out  1  state != IDLE
- rd_addr  in  ADDR_WIDTH  host read address
- rd_data  out  DATA_WIDTH  Q[rd_addr], 1-cycle registered

Behaviour:
- Address mapping: addr = ((row*COLS)+col)*ACTIONS + action.
- Reset (rst low, async):
  - FSM goes to IDLE and all Q entries go to 0.
  - done_valid, done_err, done_addr, done_q, done_best_action and rd_data go to 0.
  - Any in-flight update is discarded.
- req_ready = (state==IDLE) && !clear. Acceptance happens on a rising edge with req_valid && req_ready; all inputs are latched at that edge.
- FSM: IDLE -> SCAN -> CALC -> WRITE -> IDLE; IDLE -> CLEAR -> IDLE.
- SCAN:
  - Takes ACTIONS cycles, one next-state entry read per cycle.
  - Running max uses a strict greater-than compare, so ties keep the lowest action index.
- CALC (1 cycle), all arithmetic in DATA_WIDTH+2 signed:
  - target = reward + (terminal ? 0 : max >>> GAMMA_SHIFT)
  - delta = target - Q[addr]
  - q_new = Q[addr] + (delta >>> ALPHA_SHIFT), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
  - The shift is arithmetic (floor).
- WRITE edge:
  - Writes Q[addr] and registers done_* outputs; done_valid is high for exactly the following cycle.
  - Latency from the accepting edge to done_valid rising is ACTIONS+2 edges. req_ready is high in the same cycle done_valid is high.
- Out-of-range input: if row>=ROWS, col>=COLS, next_row>=ROWS or next_col>=COLS:
  - The request is still accepted and takes the same latency.
  - No table write; done_err=1; done_q=0.
- s' equal to s: the scan uses the pre-update values.
- CLEAR:
  - Entered when clear=1 in IDLE; clear wins over a simultaneous req_valid.
  - Zeroes one entry per cycle for TABLE_SIZE cycles, then returns to IDLE.
  - clear is ignored outside IDLE.
- Host read:
  - rd_data <= Q[rd_addr] every edge, in any state.
  - Same-edge read and write of one address returns the old value.

Decomposition:
- Package q_learn_pkg holds:
  - state enum (IDLE, SCAN, CALC, WRITE, CLEAR)
  - sat_to_width function
  - address-calc function
- One sub-module, q_max_scan: sequential running max/argmax with start/step/result.

Test Plan:
- Defaults, empty table; (0,0,a0)->(0,1), reward=10 -> done_addr=0, done_q=5, done_best_action=0, done_valid exactly 6 edges after accept; a second identical update -> done_q=7.
- With Q[0]=5 from the previous case; (0,1,a2)->(0,0), reward=0 -> target=2, done_addr=6, done_q=1, done_best_action=0.
- ALPHA_SHIFT=0 build; (1,1,a0) terminal reward=100 -> Q[24]=100; then (1,2,a0)->(1,1), reward=127 -> target 177, done_q=127 (saturated).
- row=5 request -> done_err=1, done_q=0, all entries unchanged via the rd port, req_ready restored after 6 edges.
- clear pulse together with req_valid in IDLE -> request not accepted, busy and req_ready low for 100 cycles, all rd_data reads return 0 afterwards.
- rst low during SCAN -> no done_valid ever; table reads 0; req_ready=1 on the first edge after release.

Source files
------------

// File: rtl/q_learn_pkg.sv
// Shared types and helpers for the Q-learning update engine.
package q_learn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_CALC,
        ST_WRITE,
        ST_CLEAR
    } state_e;

    // Clamp a signed value into the range representable by a width-bit signed word.
    function automatic int sat_to_width(input int value, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    function automatic int calc_addr(input int row, input int col, input int action,
                                     input int cols, input int actions);
        return ((row * cols) + col) * actions + action;
    endfunction

endpackage

// File: rtl/q_max_scan.sv
// Sequential running max / argmax over one state's action values, one value per step.
module q_max_scan
    import q_learn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACTIONS    = 4,
    localparam int ACT_WIDTH = $clog2(ACTIONS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         step,
    input  logic signed [DATA_WIDTH-1:0] din,
    output logic        [ACT_WIDTH-1:0]  idx,
    output logic                         last,
    output logic signed [DATA_WIDTH-1:0] max_val,
    output logic        [ACT_WIDTH-1:0]  max_idx
);

    logic        [ACT_WIDTH-1:0]  idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic        [ACT_WIDTH-1:0]  arg_q, arg_d;

    always_comb begin
        idx_d = idx_q;
        max_d = max_q;
        arg_d = arg_q;
        if (start) begin
            idx_d = '0;
        end else if (step) begin
            // First element seeds the max; strict compare keeps the lowest index on ties.
            if ((idx_q == '0) || (din > max_q)) begin
                max_d = din;
                arg_d = idx_q;
            end
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            max_q <= '0;
            arg_q <= '0;
        end else begin
            idx_q <= idx_d;
            max_q <= max_d;
            arg_q <= arg_d;
        end
    end

    assign idx     = idx_q;
    assign last    = (idx_q == ACT_WIDTH'(ACTIONS - 1));
    assign max_val = max_q;
    assign max_idx = arg_q;

endmodule

// File: rtl/q_update_engine.sv
// Q-learning update engine: owns the Q-table, performs one (s,a,r,s') update per request,
// and offers a registered host read port plus a table-clear sequence.
module q_update_engine
    import q_learn_pkg::*;
#(
    parameter int ROWS        = 5,
    parameter int COLS        = 5,
    parameter int ACTIONS     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ALPHA_SHIFT = 1,
    parameter int GAMMA_SHIFT = 1,
    parameter int TABLE_SIZE  = ROWS * COLS * ACTIONS,
    parameter int ADDR_WIDTH  = $clog2(TABLE_SIZE),
    localparam int ACT_WIDTH  = $clog2(ACTIONS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic        [2:0]            row,
    input  logic        [2:0]            col,
    input  logic        [2:0]            next_row,
    input  logic        [2:0]            next_col,
    input  logic        [ACT_WIDTH-1:0]  action,
    input  logic signed [DATA_WIDTH-1:0] reward,
    input  logic                         terminal,
    output logic                         done_valid,
    output logic        [ADDR_WIDTH-1:0] done_addr,
    output logic signed [DATA_WIDTH-1:0] done_q,
    output logic        [ACT_WIDTH-1:0]  done_best_action,
    output logic                         done_err,
    input  logic                         clear,
    output logic                         busy,
    input  logic        [ADDR_WIDTH-1:0] rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    localparam int W2 = DATA_WIDTH + 2;

    state_e state_q, state_d;

    logic signed [DATA_WIDTH-1:0] q_mem_q [TABLE_SIZE];
    logic signed [DATA_WIDTH-1:0] q_mem_d [TABLE_SIZE];

    logic        [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic        [ADDR_WIDTH-1:0] nbase_q, nbase_d;
    logic        [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic signed [DATA_WIDTH-1:0] reward_q, reward_d;
    logic signed [DATA_WIDTH-1:0] q_new_q, q_new_d;
    logic                         terminal_q, terminal_d;
    logic                         err_q, err_d;

    logic                         done_valid_q, done_valid_d;
    logic        [ADDR_WIDTH-1:0] done_addr_q, done_addr_d;
    logic signed [DATA_WIDTH-1:0] done_q_q, done_q_d;
    logic        [ACT_WIDTH-1:0]  done_ba_q, done_ba_d;
    logic                         done_err_q, done_err_d;
    logic signed [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                         wr_en;
    logic        [ADDR_WIDTH-1:0] wr_addr;
    logic signed [DATA_WIDTH-1:0] wr_data;

    logic                         accept;
    logic        [ACT_WIDTH-1:0]  scan_idx;
    logic                         scan_last;
    logic signed [DATA_WIDTH-1:0] scan_max;
    logic        [ACT_WIDTH-1:0]  scan_arg;
    logic        [ADDR_WIDTH-1:0] scan_addr;
    logic signed [DATA_WIDTH-1:0] scan_rd, old_rd, host_rd;
    logic signed [W2-1:0]         old_ext, boot_ext, target, delta, q_sum;
    logic                         in_err;

    assign accept    = (state_q == ST_IDLE) && !clear && req_valid;
    assign scan_addr = nbase_q + ADDR_WIDTH'(scan_idx);

    // Guarded table reads: addresses past the table end read as zero.
    always_comb begin
        scan_rd = '0;
        old_rd  = '0;
        host_rd = '0;
        if (32'(scan_addr) < TABLE_SIZE) scan_rd = q_mem_q[scan_addr];
        if (32'(addr_q) < TABLE_SIZE)    old_rd  = q_mem_q[addr_q];
        if (32'(rd_addr) < TABLE_SIZE)   host_rd = q_mem_q[rd_addr];
    end

    q_max_scan #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACTIONS   (ACTIONS)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .start  (accept),
        .step   (state_q == ST_SCAN),
        .din    (scan_rd),
        .idx    (scan_idx),
        .last   (scan_last),
        .max_val(scan_max),
        .max_idx(scan_arg)
    );

    // Bootstrap and update arithmetic, widened so intermediate terms never wrap.
    always_comb begin
        old_ext  = W2'(old_rd);
        boot_ext = '0;
        if (!terminal_q) begin
            boot_ext = W2'(scan_max) >>> GAMMA_SHIFT;
        end
        target = W2'(reward_q) + boot_ext;
        delta  = target - old_ext;
        q_sum  = old_ext + (delta >>> ALPHA_SHIFT);
    end

    assign in_err = (32'(row) >= ROWS) || (32'(col) >= COLS) ||
                    (32'(next_row) >= ROWS) || (32'(next_col) >= COLS) ||
                    (32'(action) >= ACTIONS);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        nbase_d      = nbase_q;
        clr_cnt_d    = clr_cnt_q;
        reward_d     = reward_q;
        terminal_d   = terminal_q;
        err_d        = err_q;
        q_new_d      = q_new_q;
        done_valid_d = 1'b0;
        done_addr_d  = done_addr_q;
        done_q_d     = done_q_q;
        done_ba_d    = done_ba_q;
        done_err_d   = done_err_q;
        wr_en        = 1'b0;
        wr_addr      = addr_q;
        wr_data      = q_new_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (req_valid) begin
                    state_d    = ST_SCAN;
                    reward_d   = reward;
                    terminal_d = terminal;
                    err_d      = in_err;
                    addr_d     = in_err ? '0 :
                        ADDR_WIDTH'(calc_addr(int'(row), int'(col), int'(action), COLS, ACTIONS));
                    nbase_d    = in_err ? '0 :
                        ADDR_WIDTH'(calc_addr(int'(next_row), int'(next_col), 0, COLS, ACTIONS));
                end
            end
            ST_SCAN: begin
                if (scan_last) state_d = ST_CALC;
            end
            ST_CALC: begin
                q_new_d = DATA_WIDTH'(sat_to_width(int'(q_sum), DATA_WIDTH));
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en        = !err_q;
                done_valid_d = 1'b1;
                done_addr_d  = addr_q;
                done_q_d     = err_q ? '0 : q_new_q;
                done_ba_d    = scan_arg;
                done_err_d   = err_q;
                state_d      = ST_IDLE;
            end
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_WIDTH'(TABLE_SIZE - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-before-write: the host port samples q_mem_q, so a same-edge write shows next cycle.
    always_comb begin
        q_mem_d   = q_mem_q;
        rd_data_d = host_rd;
        if (wr_en) q_mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            nbase_q      <= '0;
            clr_cnt_q    <= '0;
            reward_q     <= '0;
            terminal_q   <= 1'b0;
            err_q        <= 1'b0;
            q_new_q      <= '0;
            done_valid_q <= 1'b0;
            done_addr_q  <= '0;
            done_q_q     <= '0;
            done_ba_q    <= '0;
            done_err_q   <= 1'b0;
            rd_data_q    <= '0;
            for (int i = 0; i < TABLE_SIZE; i++) q_mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            nbase_q      <= nbase_d;
            clr_cnt_q    <= clr_cnt_d;
            reward_q     <= reward_d;
            terminal_q   <= terminal_d;
            err_q        <= err_d;
            q_new_q      <= q_new_d;
            done_valid_q <= done_valid_d;
            done_addr_q  <= done_addr_d;
            done_q_q     <= done_q_d;
            done_ba_q    <= done_ba_d;
            done_err_q   <= done_err_d;
            rd_data_q    <= rd_data_d;
            for (int i = 0; i < TABLE_SIZE; i++) q_mem_q[i] <= q_mem_d[i];
        end
    end

    assign req_ready        = (state_q == ST_IDLE) && !clear;
    assign busy             = (state_q != ST_IDLE);
    assign done_valid       = done_valid_q;
    assign done_addr        = done_addr_q;
    assign done_q           = done_q_q;
    assign done_best_action = done_ba_q;
    assign done_err         = done_err_q;
    assign rd_data          = rd_data_q;

endmodule

// File: tb/tb_q_update_engine.sv
// Scoreboard bench: instance 0 uses default shifts, instance 1 uses ALPHA_SHIFT=0.
module tb_q_update_engine;

    typedef struct {
        int addr;
        int q;
        int ba;
        int err;
        int acc;
        bit chk_full;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid  [2];
    logic              req_ready  [2];
    logic        [2:0] row_s      [2];
    logic        [2:0] col_s      [2];
    logic        [2:0] nrow_s     [2];
    logic        [2:0] ncol_s     [2];
    logic        [1:0] action_s   [2];
    logic signed [7:0] reward_s   [2];
    logic              terminal_s [2];
    logic              done_valid [2];
    logic        [6:0] done_addr  [2];
    logic signed [7:0] done_q     [2];
    logic        [1:0] done_ba    [2];
    logic              done_err   [2];
    logic              clear_s    [2];
    logic              busy       [2];
    logic        [6:0] rd_addr    [2];
    logic signed [7:0] rd_data    [2];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   model0 [100];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        q_update_engine #(.ALPHA_SHIFT(gi == 0 ? 1 : 0)) dut (
            .clk             (clk),
            .rst             (rst),
            .req_valid       (req_valid[gi]),
            .req_ready       (req_ready[gi]),
            .row             (row_s[gi]),
            .col             (col_s[gi]),
            .next_row        (nrow_s[gi]),
            .next_col        (ncol_s[gi]),
            .action          (action_s[gi]),
            .reward          (reward_s[gi]),
            .terminal        (terminal_s[gi]),
            .done_valid      (done_valid[gi]),
            .done_addr       (done_addr[gi]),
            .done_q          (done_q[gi]),
            .done_best_action(done_ba[gi]),
            .done_err        (done_err[gi]),
            .clear           (clear_s[gi]),
            .busy            (busy[gi]),
            .rd_addr         (rd_addr[gi]),
            .rd_data         (rd_data[gi])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst && done_valid[d]) begin
                if (qsize(d) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done dut%0d: got done_valid=1 expected none", d);
                end else begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    $display("dut%0d done addr=%0d q=%0d best=%0d err=%0d latency=%0d",
                             d, done_addr[d], done_q[d], done_ba[d], done_err[d], cyc - e.acc);
                    chk($sformatf("dut%0d_q", d), int'(done_q[d]), e.q);
                    chk($sformatf("dut%0d_err", d), int'(done_err[d]), e.err);
                    chk($sformatf("dut%0d_latency", d), cyc - e.acc, 6);
                    chk($sformatf("dut%0d_ready_at_done", d), int'(req_ready[d]), 1);
                    if (e.chk_full) begin
                        chk($sformatf("dut%0d_addr", d), int'(done_addr[d]), e.addr);
                        chk($sformatf("dut%0d_best", d), int'(done_ba[d]), e.ba);
                    end
                end
            end
        end
    end

    task automatic do_req(input int d, input int r, input int c, input int a,
                          input int nr, input int nc, input int rew, input int term,
                          input int eaddr, input int eq, input int eba, input int eerr,
                          input bit full);
        exp_t e;
        row_s[d]      = 3'(r);
        col_s[d]      = 3'(c);
        action_s[d]   = 2'(a);
        nrow_s[d]     = 3'(nr);
        ncol_s[d]     = 3'(nc);
        reward_s[d]   = 8'(rew);
        terminal_s[d] = term[0];
        req_valid[d]  = 1'b1;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        e.addr = eaddr; e.q = eq; e.ba = eba; e.err = eerr; e.acc = cyc; e.chk_full = full;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        for (int k = 0; k < 20; k++) begin
            if (qsize(d) == 0) break;
            @(posedge clk);
        end
        if (qsize(d) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout dut%0d: got no done_valid expected one within 20 cycles", d);
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input int d, input int addr, input int exp);
        rd_addr[d] = 7'(addr);
        @(posedge clk);
        #1;
        chk($sformatf("dut%0d_rd[%0d]", d, addr), int'(rd_data[d]), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit ready_low_ok;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; row_s[d] = '0; col_s[d] = '0; nrow_s[d] = '0; ncol_s[d] = '0;
            action_s[d] = '0; reward_s[d] = '0; terminal_s[d] = 1'b0; clear_s[d] = 1'b0;
            rd_addr[d] = '0;
        end
        for (int i = 0; i < 100; i++) model0[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done_valid", int'(done_valid[0]), 0);
        chk("reset_done_q", int'(done_q[0]), 0);
        chk("reset_done_err", int'(done_err[0]), 0);
        chk("reset_rd_data", int'(rd_data[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Default engine: alpha=gamma=1/2.
        do_req(0, 0, 0, 0, 0, 1, 10, 0,  0, 5, 0, 0, 1); model0[0] = 5;
        do_req(0, 0, 1, 2, 0, 0,  0, 0,  6, 1, 0, 0, 1); model0[6] = 1;
        do_req(0, 0, 0, 0, 0, 1, 10, 0,  0, 7, 2, 0, 1); model0[0] = 7;
        do_req(0, 2, 0, 1, 2, 1, -7, 0, 41, -4, 0, 0, 1); model0[41] = -4;
        do_req(0, 0, 0, 1, 0, 0,  0, 0,  1, 1, 0, 0, 1); model0[1] = 1;
        read_chk(0, 0, 7);
        read_chk(0, 6, 1);

        // Out-of-range row: accepted, flagged, no table change.
        do_req(0, 5, 0, 0, 0, 0, 50, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 100; i++) read_chk(0, i, model0[i]);

        // alpha=1 engine: saturation on the positive side.
        do_req(1, 1, 1, 0, 0, 0, 100, 1, 24, 100, 0, 0, 1);
        do_req(1, 1, 2, 0, 1, 1, 127, 0, 28, 127, 0, 0, 1);
        read_chk(1, 24, 100);
        read_chk(1, 28, 127);

        // Clear beats a simultaneous request.
        clear_s[0]   = 1'b1;
        req_valid[0] = 1'b1;
        row_s[0] = 3'd1; col_s[0] = 3'd1; nrow_s[0] = 3'd0; ncol_s[0] = 3'd0; reward_s[0] = 8'sd20;
        @(posedge clk);
        #1;
        clear_s[0]   = 1'b0;
        req_valid[0] = 1'b0;
        chk("clear_busy", int'(busy[0]), 1);
        n = 0;
        ready_low_ok = 1'b1;
        while (busy[0] && n < 200) begin
            if (req_ready[0]) ready_low_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk("clear_cycles", n, 100);
        chk("clear_ready_low", int'(ready_low_ok), 1);
        for (int i = 0; i < 100; i++) read_chk(0, i, 0);

        // Reset in the middle of a scan discards the update.
        do_req(0, 0, 0, 0, 0, 1, 10, 0, 0, 5, 0, 0, 1);
        read_chk(0, 0, 5);
        row_s[0] = 3'd0; col_s[0] = 3'd0; action_s[0] = 2'd0; nrow_s[0] = 3'd0; ncol_s[0] = 3'd1;
        reward_s[0] = 8'sd10; terminal_s[0] = 1'b0;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("scan_busy", int'(busy[0]), 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", int'(req_ready[0]), 1);
        chk("post_reset_busy", int'(busy[0]), 0);
        repeat (10) @(posedge clk);
        #1;
        read_chk(0, 0, 0);
        read_chk(0, 6, 0);
        read_chk(1, 24, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
